// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM state encoding, error codes
// and the default frame start marker.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    localparam logic [1:0] ERR_CHKSUM  = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;
    localparam logic [1:0] ERR_LEN     = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte stream from the UART receiver and the ready-handshaked instruction-memory write port.
interface uart_boot_loader_if;
    logic        i_Rx_DV;
    logic [7:0]  i_Rx_Byte;
    logic        o_Mem_We;
    logic [31:0] o_Mem_Addr;
    logic [31:0] o_Mem_Wdata;
    logic        i_Mem_Ready;

    modport master (
        input  i_Rx_DV, i_Rx_Byte, i_Mem_Ready,
        output o_Mem_We, o_Mem_Addr, o_Mem_Wdata
    );

    modport slave (
        output i_Rx_DV, i_Rx_Byte, i_Mem_Ready,
        input  o_Mem_We, o_Mem_Addr, o_Mem_Wdata
    );
endinterface

// File: rtl/boot_timeout_ctr.sv
// Inter-byte watchdog: down-counter reloaded on clear, expires when the terminal count is hit
// while enabled. Holding enable low freezes the count.
module boot_timeout_ctr #(
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expire
);
    localparam int            CW   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] remain;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            remain <= LOAD;
        end else if (i_Clear) begin
            remain <= LOAD;
        end else if (i_Enable && (remain != '0)) begin
            remain <= remain - 1'b1;
        end
    end

    assign o_Expire = i_Enable && !i_Clear && (remain == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// Parses SYNC/LEN/payload/CHK frames from the UART receiver, writes little-endian words
// to instruction memory and releases the CPU only after a frame passes its checksum.
//   state  | meaning                     state  | meaning
//   IDLE   | wait for SYNC               WRITE  | word on memory port, wait ready
//   LEN_LO | expect length low byte      CHK    | expect checksum byte
//   LEN_HI | expect length high byte     DONE   | frame loaded, CPU released
//   DATA   | collect payload bytes       ERROR  | frame failed, CPU held
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096,
    parameter int          TIMEOUT_CLKS = 5000000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    uart_boot_loader_if.master bus,
    output logic               o_Cpu_Hold,
    output logic               o_Done,
    output logic               o_Error,
    output logic [1:0]         o_Err_Code,
    output logic [15:0]        o_Word_Count
);
    boot_state_t state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] wc_q, wc_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  code_q, code_d;

    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [7:0]  chk_next;
    logic [15:0] len_rx;
    logic        tmo_clear, tmo_enable, tmo_expire;

    assign rx_dv    = bus.i_Rx_DV;
    assign rx_byte  = bus.i_Rx_Byte;
    assign chk_next = chk_q ^ rx_byte;
    assign len_rx   = {rx_byte, len_q[7:0]};

    // Watchdog runs only mid-frame and is frozen while the memory port stalls us.
    assign tmo_enable = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK};
    assign tmo_clear  = rx_dv || (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});

    boot_timeout_ctr #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .i_Clear  (tmo_clear),
        .i_Enable (tmo_enable),
        .o_Expire (tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wc_d    = wc_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;
        code_d  = code_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (rx_dv && (rx_byte == SYNC_BYTE)) begin
                    state_d = ST_LEN_LO;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = ERR_CHKSUM;
                    chk_d   = 8'h00;
                    wc_d    = 16'h0000;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_LEN_LO: begin
                if (rx_dv) begin
                    len_d[7:0] = rx_byte;
                    chk_d      = chk_next;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_dv) begin
                    len_d = len_rx;
                    chk_d = chk_next;
                    idx_d = 2'd0;
                    if (int'(len_rx) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        code_d  = ERR_LEN;
                    end else if (len_rx == 16'h0000) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_dv) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = rx_byte;
                    chk_d = chk_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.i_Mem_Ready) begin
                    we_d   = 1'b0;
                    addr_d = addr_q + 32'd4;
                    wc_d   = wc_q + 16'd1;
                    idx_d  = 2'd0;
                    // A byte landing with ready belongs to whatever follows this word.
                    if ((wc_q + 16'd1) == len_q) begin
                        state_d = ST_CHK;
                        if (rx_dv) begin
                            if (rx_byte == chk_q) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end else begin
                                state_d = ST_ERROR;
                                error_d = 1'b1;
                                code_d  = ERR_CHKSUM;
                            end
                        end
                    end else begin
                        state_d = ST_DATA;
                        if (rx_dv) begin
                            wdata_d[7:0] = rx_byte;
                            chk_d        = chk_next;
                            idx_d        = 2'd1;
                        end
                    end
                end else if (rx_dv) begin
                    we_d    = 1'b0;
                    state_d = ST_ERROR;
                    error_d = 1'b1;
                    code_d  = ERR_OVERRUN;
                end
            end
            ST_CHK: begin
                if (rx_dv) begin
                    if (rx_byte == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                        code_d  = ERR_CHKSUM;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_expire) begin
            state_d = ST_ERROR;
            we_d    = 1'b0;
            error_d = 1'b1;
            code_d  = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            len_q   <= 16'h0000;
            idx_q   <= 2'd0;
            chk_q   <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'h0000_0000;
            wc_q    <= 16'h0000;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= ERR_CHKSUM;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wc_q    <= wc_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    assign bus.o_Mem_We    = we_q;
    assign bus.o_Mem_Addr  = addr_q;
    assign bus.o_Mem_Wdata = wdata_q;
    assign o_Cpu_Hold      = hold_q;
    assign o_Done          = done_q;
    assign o_Error         = error_q;
    assign o_Err_Code      = code_q;
    assign o_Word_Count    = wc_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
`timescale 1ns/1ps
// Bench for uart_boot_loader: directed frames plus random frames checked against a
// byte-level frame model; a memory responder with programmable ready delay records writes.
module tb_uart_boot_loader;
    import boot_pkg::*;

    localparam logic [31:0] TB_BASE = 32'h0000_0100;
    localparam int          TB_MAX  = 4096;
    localparam int          TB_TMO  = 1000;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        o_Cpu_Hold, o_Done, o_Error;
    logic [1:0]  o_Err_Code;
    logic [15:0] o_Word_Count;

    uart_boot_loader_if bus ();

    uart_boot_loader #(
        .BASE_ADDR    (TB_BASE),
        .MAX_WORDS    (TB_MAX),
        .TIMEOUT_CLKS (TB_TMO),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .bus          (bus),
        .o_Cpu_Hold   (o_Cpu_Hold),
        .o_Done       (o_Done),
        .o_Error      (o_Error),
        .o_Err_Code   (o_Err_Code),
        .o_Word_Count (o_Word_Count)
    );

    always #5 i_Clock = ~i_Clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ready_delay = 0;
    bit          ready_block = 1'b0;
    int          we_cnt = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  tx[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_ok;
    logic [15:0] exp_wc;

    // Memory responder: raises ready once the request has waited ready_delay cycles.
    always @(negedge i_Clock) begin
        if (bus.o_Mem_We === 1'b1) begin
            bus.i_Mem_Ready = !ready_block && (we_cnt >= ready_delay);
            if (bus.i_Mem_Ready) begin
                obs_addr.push_back(bus.o_Mem_Addr);
                obs_data.push_back(bus.o_Mem_Wdata);
            end
            we_cnt++;
        end else begin
            we_cnt = 0;
            bus.i_Mem_Ready = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic send_raw(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        tick(1);
        bus.i_Rx_DV   = 1'b0;
    endtask

    // Sends a byte, then lets any write it triggered finish before the next byte.
    task automatic send_b(input logic [7:0] b, input int gap);
        send_raw(b);
        if (bus.o_Mem_We === 1'b1) begin
            for (int k = 0; k < 60 && bus.o_Mem_We === 1'b1; k++) tick(1);
            n_cmp++;
            if (bus.o_Mem_We !== 1'b0) begin
                n_bad++;
                $display("FAIL write_wait: o_Mem_We=%b still high, required 0", bus.o_Mem_We);
            end
        end
        tick(gap);
    endtask

    function automatic void build_frame(input int len, input bit bad);
        logic [7:0] x;
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(8'(len));
        tx.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) tx.push_back(8'($urandom));
        x = 8'h00;
        for (int i = 1; i < tx.size(); i++) x ^= tx[i];
        if (bad) x ^= 8'($urandom_range(1, 255));
        tx.push_back(x);
    endfunction

    // Reference: decode a well-formed frame in tx into the expected writes and verdict.
    function automatic void model_frame();
        int         len;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        len = int'({tx[2], tx[1]});
        x = 8'h00;
        for (int i = 1; i < tx.size() - 1; i++) x ^= tx[i];
        for (int w = 0; w < len; w++) begin
            exp_addr.push_back(TB_BASE + 32'(4 * w));
            exp_data.push_back({tx[6 + 4*w], tx[5 + 4*w], tx[4 + 4*w], tx[3 + 4*w]});
        end
        exp_ok = (x == tx[tx.size() - 1]);
        exp_wc = 16'(len);
    endfunction

    task automatic test_reset();
        i_Reset = 1'b1;
        bus.i_Rx_DV = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        tick(3);
        n_cmp++; if (bus.o_Mem_We !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b need 0", bus.o_Mem_We); end
        n_cmp++; if (bus.o_Mem_Addr !== TB_BASE) begin n_bad++; $display("FAIL rst_addr: got %h need %h", bus.o_Mem_Addr, TB_BASE); end
        n_cmp++; if (bus.o_Mem_Wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h need 0", bus.o_Mem_Wdata); end
        n_cmp++; if (o_Cpu_Hold !== 1'b1) begin n_bad++; $display("FAIL rst_hold: got %b need 1", o_Cpu_Hold); end
        n_cmp++; if ({o_Done, o_Error} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got done/err %b%b need 00", o_Done, o_Error); end
        n_cmp++; if (o_Err_Code !== 2'b00) begin n_bad++; $display("FAIL rst_code: got %b need 00", o_Err_Code); end
        n_cmp++; if (o_Word_Count !== 16'h0) begin n_bad++; $display("FAIL rst_wc: got %0d need 0", o_Word_Count); end
        i_Reset = 1'b0;
        tick(2);
    endtask

    task automatic test_example();
        int base;
        base = obs_addr.size();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        for (int i = 0; i < tx.size(); i++) send_b(tx[i], 1);
        tick(2);
        n_cmp++; if (obs_addr.size() - base != 2) begin n_bad++; $display("FAIL ex_nwrites: got %0d need 2", obs_addr.size() - base); end
        n_cmp++; if (obs_addr[base] !== TB_BASE || obs_data[base] !== 32'h1234_5678) begin n_bad++;
            $display("FAIL ex_w0: got %h/%h need %h/12345678", obs_addr[base], obs_data[base], TB_BASE); end
        n_cmp++; if (obs_addr[base+1] !== TB_BASE + 32'd4 || obs_data[base+1] !== 32'hDEAD_BEEF) begin n_bad++;
            $display("FAIL ex_w1: got %h/%h need %h/deadbeef", obs_addr[base+1], obs_data[base+1], TB_BASE + 32'd4); end
        n_cmp++; if ({o_Done, o_Error, o_Cpu_Hold} !== 3'b100) begin n_bad++;
            $display("FAIL ex_status: got done/err/hold %b%b%b need 100", o_Done, o_Error, o_Cpu_Hold); end
        n_cmp++; if (o_Word_Count !== 16'd2) begin n_bad++; $display("FAIL ex_wc: got %0d need 2", o_Word_Count); end
    endtask

    task automatic test_bad_chk();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
        for (int i = 0; i < tx.size(); i++) send_b(tx[i], 0);
        tick(2);
        n_cmp++; if ({o_Done, o_Error, o_Cpu_Hold} !== 3'b011) begin n_bad++;
            $display("FAIL badchk_status: got done/err/hold %b%b%b need 011", o_Done, o_Error, o_Cpu_Hold); end
        n_cmp++; if (o_Err_Code !== ERR_CHKSUM) begin n_bad++; $display("FAIL badchk_code: got %b need 00", o_Err_Code); end
        tx[tx.size() - 1] = 8'h28;
        for (int i = 0; i < tx.size(); i++) send_b(tx[i], 0);
        tick(2);
        n_cmp++; if ({o_Done, o_Error, o_Cpu_Hold} !== 3'b100) begin n_bad++;
            $display("FAIL resend_status: got done/err/hold %b%b%b need 100", o_Done, o_Error, o_Cpu_Hold); end
    endtask

    task automatic test_overrun();
        ready_block = 1'b1;
        build_frame(2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send_raw(tx[i]);
            tick(1);
        end
        send_raw(tx[7]);
        tick(2);
        n_cmp++; if ({o_Error, o_Err_Code} !== {1'b1, ERR_OVERRUN}) begin n_bad++;
            $display("FAIL overrun: got err/code %b/%b need 1/10", o_Error, o_Err_Code); end
        n_cmp++; if ({bus.o_Mem_We, o_Cpu_Hold} !== 2'b01) begin n_bad++;
            $display("FAIL overrun_we_hold: got %b%b need 01", bus.o_Mem_We, o_Cpu_Hold); end
        ready_block = 1'b0;
        tick(2);
    endtask

    task automatic test_zero_len();
        int base;
        base = obs_addr.size();
        send_b(8'h00, 1);
        send_b(8'hFF, 1);
        n_cmp++; if (o_Error !== 1'b1) begin n_bad++; $display("FAIL noise_ignored: got err %b need 1", o_Error); end
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < tx.size(); i++) send_b(tx[i], 0);
        tick(3);
        n_cmp++; if (obs_addr.size() != base) begin n_bad++; $display("FAIL zero_writes: got %0d need 0", obs_addr.size() - base); end
        n_cmp++; if ({o_Done, o_Error, o_Cpu_Hold} !== 3'b100 || o_Word_Count !== 16'd0) begin n_bad++;
            $display("FAIL zero_status: got %b%b%b wc %0d need 100 wc 0", o_Done, o_Error, o_Cpu_Hold, o_Word_Count); end
    endtask

    task automatic test_ready_delay();
        int cyc;
        ready_delay = 3;
        build_frame(1, 1'b0);
        model_frame();
        for (int i = 0; i < 6; i++) send_b(tx[i], 0);
        send_raw(tx[6]);
        cyc = 0;
        while (bus.o_Mem_We === 1'b1 && cyc < 20) begin
            @(negedge i_Clock);
            n_cmp++;
            if (bus.o_Mem_Addr !== exp_addr[0] || bus.o_Mem_Wdata !== exp_data[0]) begin n_bad++;
                $display("FAIL delay_stable cyc=%0d: got %h/%h need %h/%h", cyc, bus.o_Mem_Addr, bus.o_Mem_Wdata, exp_addr[0], exp_data[0]); end
            cyc++;
            @(posedge i_Clock);
            #1;
        end
        n_cmp++; if (cyc != 4) begin n_bad++; $display("FAIL delay_we_len: got %0d cycles need 4", cyc); end
        send_b(tx[7], 0);
        tick(2);
        n_cmp++; if (o_Done !== 1'b1 || o_Word_Count !== 16'd1) begin n_bad++;
            $display("FAIL delay_done: got done %b wc %0d need 1 wc 1", o_Done, o_Word_Count); end
        ready_delay = 0;
    endtask

    task automatic test_back_to_back();
        int base;
        ready_delay = 0;
        base = obs_addr.size();
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
        model_frame();
        for (int i = 0; i < tx.size(); i++) send_raw(tx[i]);
        tick(3);
        n_cmp++; if (obs_addr.size() - base != 2) begin n_bad++; $display("FAIL b2b_nwrites: got %0d need 2", obs_addr.size() - base); end
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (obs_addr[base+w] !== exp_addr[w] || obs_data[base+w] !== exp_data[w]) begin n_bad++;
                $display("FAIL b2b_w%0d: got %h/%h need %h/%h", w, obs_addr[base+w], obs_data[base+w], exp_addr[w], exp_data[w]); end
        end
        n_cmp++; if ({o_Done, o_Error} !== 2'b10 || o_Word_Count !== 16'd2) begin n_bad++;
            $display("FAIL b2b_status: got done/err %b%b wc %0d need 10 wc 2", o_Done, o_Error, o_Word_Count); end
    endtask

    task automatic test_random();
        int         base;
        logic [7:0] nb;
        for (int it = 0; it < 25; it++) begin
            ready_delay = $urandom_range(0, 2);
            nb = 8'($urandom);
            if (nb == 8'hA5) nb = 8'h00;
            send_b(nb, 0);
            build_frame($urandom_range(0, 4), ($urandom_range(0, 3) == 0));
            model_frame();
            base = obs_addr.size();
            for (int i = 0; i < tx.size(); i++) send_b(tx[i], $urandom_range(0, 2));
            tick(2);
            n_cmp++;
            if (obs_addr.size() - base != exp_addr.size()) begin n_bad++;
                $display("FAIL rnd_nwrites it=%0d: got %0d need %0d", it, obs_addr.size() - base, exp_addr.size()); end
            for (int w = 0; w < exp_addr.size(); w++) begin
                n_cmp++;
                if (obs_addr[base+w] !== exp_addr[w] || obs_data[base+w] !== exp_data[w]) begin n_bad++;
                    $display("FAIL rnd_write it=%0d w=%0d: got %h/%h need %h/%h", it, w, obs_addr[base+w], obs_data[base+w], exp_addr[w], exp_data[w]); end
            end
            n_cmp++;
            if ({o_Done, o_Error, o_Cpu_Hold} !== {exp_ok, !exp_ok, !exp_ok}) begin n_bad++;
                $display("FAIL rnd_status it=%0d: got done/err/hold %b%b%b need %b%b%b", it, o_Done, o_Error, o_Cpu_Hold, exp_ok, !exp_ok, !exp_ok); end
            if (!exp_ok) begin
                n_cmp++;
                if (o_Err_Code !== ERR_CHKSUM) begin n_bad++; $display("FAIL rnd_code it=%0d: got %b need 00", it, o_Err_Code); end
            end
            n_cmp++;
            if (o_Word_Count !== exp_wc) begin n_bad++; $display("FAIL rnd_wc it=%0d: got %0d need %0d", it, o_Word_Count, exp_wc); end
        end
        ready_delay = 0;
    endtask

    task automatic test_len();
        send_b(8'hA5, 0);
        send_b(8'h01, 0);
        send_b(8'h10, 0);
        tick(1);
        n_cmp++; if ({o_Error, o_Err_Code} !== {1'b1, ERR_LEN}) begin n_bad++;
            $display("FAIL len_over: got err/code %b/%b need 1/11", o_Error, o_Err_Code); end
        send_b(8'hA5, 0);
        send_b(8'h00, 0);
        send_b(8'h10, 0);
        tick(3);
        n_cmp++; if (o_Error !== 1'b0) begin n_bad++; $display("FAIL len_max_ok: got err %b need 0", o_Error); end
        i_Reset = 1'b1;
        tick(1);
        i_Reset = 1'b0;
        tick(1);
    endtask

    task automatic test_timeout();
        send_b(8'hA5, 0);
        send_raw(8'h01);
        tick(990);
        n_cmp++; if (o_Error !== 1'b0) begin n_bad++; $display("FAIL tmo_early: got err %b need 0", o_Error); end
        for (int k = 0; k < 40 && o_Error !== 1'b1; k++) tick(1);
        n_cmp++; if ({o_Error, o_Err_Code} !== {1'b1, ERR_TIMEOUT}) begin n_bad++;
            $display("FAIL tmo_code: got err/code %b/%b need 1/01", o_Error, o_Err_Code); end
    endtask

    task automatic test_reset_mid();
        build_frame(2, 1'b0);
        for (int i = 0; i < 9; i++) send_b(tx[i], 0);
        n_cmp++; if (o_Word_Count !== 16'd1) begin n_bad++; $display("FAIL mid_pre_wc: got %0d need 1", o_Word_Count); end
        i_Reset = 1'b1;
        @(negedge i_Clock);
        n_cmp++;
        if (bus.o_Mem_We !== 1'b0 || bus.o_Mem_Addr !== TB_BASE || bus.o_Mem_Wdata !== 32'h0) begin n_bad++;
            $display("FAIL mid_rst_bus: got we %b addr %h data %h need 0 %h 0", bus.o_Mem_We, bus.o_Mem_Addr, bus.o_Mem_Wdata, TB_BASE); end
        n_cmp++;
        if ({o_Cpu_Hold, o_Done, o_Error, o_Err_Code} !== 5'b10000 || o_Word_Count !== 16'd0) begin n_bad++;
            $display("FAIL mid_rst_status: got hold/done/err/code %b%b%b%b wc %0d need 10000 wc 0", o_Cpu_Hold, o_Done, o_Error, o_Err_Code, o_Word_Count); end
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_example();
        test_bad_chk();
        test_overrun();
        test_zero_len();
        test_ready_delay();
        test_back_to_back();
        test_random();
        test_len();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
